// File: rtl/fixed_to_fp_seq_ci_if.sv
// Custom-instruction bus for the fixed-point to IEEE-754 converter.
// The master drives the request side; the slave returns done/result.
interface fixed_to_fp_seq_ci_if;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic        done;
  logic [31:0] result;

  modport master (output clk_en, start, dataa, input done, result);
  modport slave  (input clk_en, start, dataa, output done, result);
endinterface

// File: rtl/fixed_to_fp_seq_ci.sv
// Sequential sign-magnitude fixed-point to IEEE-754 single converter (one shift per cycle).
// Define FIXED_TO_FP_NEG_ZERO_EN to return -0.0 for a negative zero magnitude.
module fixed_to_fp_seq_ci #(
  parameter int INT_W  = 1,
  parameter int FRAC_W = 19
) (
  input logic                  clk,
  input logic                  reset,
  fixed_to_fp_seq_ci_if.slave  bus_io
);

  localparam int MAG_W = INT_W + FRAC_W;
  localparam logic [7:0] EXP_INIT = 8'(127 + INT_W - 1);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic [MAG_W-1:0]   mag_q, mag_d;
  logic [7:0]         exp_q, exp_d;
  logic               done_q, done_d;
  logic [31:0]        result_q, result_d;
  logic [23:0]        mantAlign;
  logic [31:0]        zeroEnc;
  logic               unused_dataa;

  // Left-justify the magnitude into a 24-bit significand; bit 23 is the hidden one.
  assign mantAlign    = 24'(mag_q) << (24 - MAG_W);
  assign unused_dataa = ^bus_io.dataa[30:MAG_W];

`ifdef FIXED_TO_FP_NEG_ZERO_EN
  assign zeroEnc = {sign_q, 31'h0};
`else
  assign zeroEnc = 32'h0000_0000;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      mag_q    <= '0;
      exp_q    <= 8'h00;
      done_q   <= 1'b0;
      result_q <= 32'h0;
    end else if (bus_io.clk_en) begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      mag_q    <= mag_d;
      exp_q    <= exp_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    mag_d    = mag_q;
    exp_d    = exp_q;
    done_d   = done_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (bus_io.start) begin
          sign_d  = bus_io.dataa[31];
          mag_d   = bus_io.dataa[MAG_W-1:0];
          exp_d   = EXP_INIT;
          state_d = NORM;
        end
      end
      NORM: begin
        if (mag_q == '0) begin
          result_d = zeroEnc;
          done_d   = 1'b1;
          state_d  = DONE;
        end else if (mantAlign[23]) begin
          result_d = {sign_q, exp_q, mantAlign[22:0]};
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 8'd1;
        end
      end
      DONE: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_io.done   = done_q;
  assign bus_io.result = result_q;

endmodule

// File: tb/tb_fixed_to_fp_seq_ci.sv
// Self-checking bench for fixed_to_fp_seq_ci: directed table, random vectors vs. a real-arithmetic model,
// and hand sequences for clock-enable stalls and mid-conversion reset.
module tb_fixed_to_fp_seq_ci;

  localparam int INT_W  = 1;
  localparam int FRAC_W = 19;
  localparam int MAG_W  = INT_W + FRAC_W;
  localparam int WINDOW = 24;

`ifdef FIXED_TO_FP_NEG_ZERO_EN
  localparam logic [31:0] NEG_ZERO = 32'h8000_0000;
`else
  localparam logic [31:0] NEG_ZERO = 32'h0000_0000;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;

  fixed_to_fp_seq_ci_if bus ();

  fixed_to_fp_seq_ci #(.INT_W(INT_W), .FRAC_W(FRAC_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dataa;
    logic [31:0] expResult;
    int          expLatency;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Value-level reference: the magnitude as a real number, re-encoded from its double representation.
  function automatic void refModel(input logic [31:0] d, output logic [31:0] r, output int lat);
    int unsigned mag;
    real         v;
    logic [63:0] bits;
    int          fexp;
    mag = 32'(d[MAG_W-1:0]);
    if (mag == 0) begin
      r   = d[31] ? NEG_ZERO : 32'h0;
      lat = 1;
    end else begin
      v    = real'(mag) / (2.0 ** FRAC_W);
      bits = $realtobits(v);
      fexp = int'(bits[62:52]) - 1023 + 127;
      r    = {d[31], 8'(fexp), bits[51:29]};
      lat  = 1 + (127 + INT_W - 1 - fexp);
    end
  endfunction

  // Issue one start and watch WINDOW cycles: first done position, its result, the final result, and pulse count.
  task automatic applyStimulus(input logic [31:0] d, input bit extraStarts,
                               output logic [31:0] r, output logic [31:0] rEnd,
                               output int lat, output int pulses);
    @(negedge clk);
    bus.dataa = d;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = -1;
    pulses = 0;
    r = 32'hDEAD_BEEF;
    for (int j = 1; j <= WINDOW; j++) begin
      if (extraStarts && lat < 0 && !bus.done) begin
        bus.start = 1'b1;
        bus.dataa = $urandom;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.done) begin
        pulses++;
        if (lat < 0) begin
          lat = j;
          r   = bus.result;
        end
      end
    end
    bus.start = 1'b0;
    rEnd = bus.result;
  endtask

  vec_t        vecs[8];
  logic [31:0] r, rEnd, expR, d;
  int          lat, pulses, expLat;

  initial begin
    vecs[0] = '{32'h0008_0000, 32'h3F80_0000, 1};
    vecs[1] = '{32'h8006_0000, 32'hBF40_0000, 2};
    vecs[2] = '{32'h000F_FFFF, 32'h3FFF_FFF0, 1};
    vecs[3] = '{32'h8000_0000, NEG_ZERO,      1};
    vecs[4] = '{32'h0000_0000, 32'h0000_0000, 1};
    vecs[5] = '{32'h0000_0001, 32'h3600_0000, 20};
    vecs[6] = '{32'h7FF8_0000, 32'h3F80_0000, 1};
    vecs[7] = '{32'h0004_0000, 32'h3F00_0000, 2};

    reset = 1'b1;
    bus.clk_en = 1'b1;
    bus.start = 1'b0;
    bus.dataa = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("resetDone", 32'(bus.done), 32'h0);
    checkOutput("resetResult", bus.result, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].dataa, 1'b0, r, rEnd, lat, pulses);
      checkOutput($sformatf("vec%0d.result", i), r, vecs[i].expResult);
      checkOutput($sformatf("vec%0d.latency", i), 32'(lat), 32'(vecs[i].expLatency));
      checkOutput($sformatf("vec%0d.pulses", i), 32'(pulses), 32'd1);
      checkOutput($sformatf("vec%0d.held", i), rEnd, vecs[i].expResult);
    end

    // Extra start pulses while converting the slowest operand must be ignored.
    applyStimulus(32'h0000_0001, 1'b1, r, rEnd, lat, pulses);
    checkOutput("extraStart.result", r, 32'h3600_0000);
    checkOutput("extraStart.latency", 32'(lat), 32'd20);
    checkOutput("extraStart.pulses", 32'(pulses), 32'd1);

    for (int i = 0; i < 40; i++) begin
      d = {$urandom} & 32'h800F_FFFF;
      d[MAG_W-1:0] = d[MAG_W-1:0] >> $urandom_range(0, MAG_W);
      d[30:MAG_W] = 11'($urandom);
      refModel(d, expR, expLat);
      applyStimulus(d, ($urandom_range(0, 1) == 1), r, rEnd, lat, pulses);
      checkOutput($sformatf("rand%0d.result(%h)", i, d), r, expR);
      checkOutput($sformatf("rand%0d.latency", i), 32'(lat), 32'(expLat));
      checkOutput($sformatf("rand%0d.pulses", i), 32'(pulses), 32'd1);
    end

    // Stall five cycles right after the start edge, then stretch the done pulse.
    @(negedge clk);
    bus.dataa = 32'h0004_0000;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.clk_en = 1'b0;
    repeat (5) @(negedge clk);
    bus.clk_en = 1'b1;
    lat = -1;
    for (int j = 6; j <= 30 && lat < 0; j++) begin
      @(negedge clk);
      if (bus.done) lat = j;
    end
    checkOutput("stall.latency", 32'(lat), 32'd7);
    checkOutput("stall.result", bus.result, 32'h3F00_0000);
    bus.clk_en = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("stall.doneStretch", 32'(bus.done), 32'h1);
    checkOutput("stall.resultHeld", bus.result, 32'h3F00_0000);
    bus.clk_en = 1'b1;
    @(negedge clk);
    checkOutput("stall.doneDrop", 32'(bus.done), 32'h0);

    // Reset three cycles into a long conversion; the result must clear and no done may follow.
    @(negedge clk);
    bus.dataa = 32'h0000_0001;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midReset.done", 32'(bus.done), 32'h0);
    checkOutput("midReset.result", bus.result, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (WINDOW) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    checkOutput("midReset.noDone", 32'(pulses), 32'd0);
    applyStimulus(32'h0008_0000, 1'b0, r, rEnd, lat, pulses);
    checkOutput("afterReset.result", r, 32'h3F80_0000);
    checkOutput("afterReset.latency", 32'(lat), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fixed_to_fp_seq_ci.md
Name: fixed_to_fp_seq_ci

Overview:
- Multi-cycle Nios II custom-instruction unit. Converts a sign-magnitude fixed-point operand to an IEEE-754 single-precision value.
- Operand layout is the converter format: sign, INT_W integer bits, FRAC_W fraction bits.
- Normalises iteratively, one left shift per cycle, under a start/done handshake.
- Sits behind the CPU custom-instruction port and returns fixed-point results to software as floats.

Parameters:
- INT_W, 1, integer magnitude bits; must be >= 1.
- FRAC_W, 19, fraction magnitude bits; INT_W+FRAC_W (MAG_W) must be <= 24, so conversion is exact.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- clk_en  input  1  when low, all state and outputs hold.
- start  input  1  one-cycle request pulse; dataa is valid in the same cycle.
- dataa  input  32  bit31 = sign; bits [MAG_W-1:0] = magnitude, binary point at FRAC_W; bits [30:MAG_W] ignored.
- done  output  1  one-cycle pulse; result is valid.
- result  output  32  IEEE-754 single; held until the next accepted start.

Behaviour:
- Reset values: done=0, result=32'h0, state=IDLE, internal magnitude and exponent registers 0.
- States:
  - IDLE: on clk_en & start, latch sign, mag = dataa[MAG_W-1:0], exp = 127+INT_W-1 (8-bit); go NORM.
  - NORM: each enabled edge:
    - if mag==0: result = zero encoding, done=1, go DONE;
    - else if mag[MAG_W-1]==1: result = {sign, exp, mag[MAG_W-2:0], (24-MAG_W) zeros}, done=1, go DONE;
    - else: mag <<= 1, exp -= 1, stay in NORM.
  - DONE: done=0, go IDLE.
- Zero encoding: 32'h00000000 regardless of sign (see Optional Feature).
- Latency: N = leading zeros of the MAG_W-bit magnitude (0..MAG_W-1; N=0 for zero input). done is high in the cycle following enabled edge k+1+N, where k is the start edge. Worst case at defaults: 20 cycles.
- Throughput: a new start is accepted only in IDLE. start in NORM or DONE is ignored, with no queuing.
- No underflow is possible under the parameter constraints. Minimum exponent is 127+INT_W-MAG_W, which is >= 104.
- clk_en low: freezes state, mag, exp, done and result. The done pulse stretches while clk_en stays low.
- Reset asserted mid-operation: immediate return to reset values. The in-flight conversion is discarded and done is never pulsed for it.
- result changes only on the edge that raises done.

Optional Feature:
- Macro FIXED_TO_FP_NEG_ZERO_EN.
- Defined: zero magnitude with sign=1 returns 32'h80000000 (IEEE -0.0); sign=0 returns 32'h00000000.
- Undefined: every zero magnitude returns 32'h00000000.
- Latency is unchanged in both cases.

Test Plan:
- Reset, then start with dataa=32'h00080000 (+1.0) -> done one cycle after the start edge, result=32'h3F800000.
- dataa=32'h80060000 (-0.75) -> done 2 cycles after start, result=32'hBF400000.
- dataa=32'h00000001 (2^-19) -> done 20 cycles after start, result=32'h36000000. Extra start pulses during conversion are ignored; exactly one done pulse occurs.
- dataa=32'h000FFFFF -> result=32'h3FFFFFF0. dataa=32'h80000000:
  - macro undefined -> 32'h00000000, done 1 cycle after start;
  - macro defined -> 32'h80000000.
- Hold clk_en low for 5 cycles mid-conversion of 32'h00040000 (+0.5) -> done delayed by exactly 5 cycles, result=32'h3F000000.
- Assert reset 3 cycles into conversion of 32'h00000001 -> done=0 and result=0 immediately. No done pulse follows; the next start converts normally.
